alu_cmd_sequencer: RTL and testbench

- Initiator side of the 8-bit ALU operand/opcode interface.
- Accepts command words over a valid/ready handshake and reads operands from a 4-entry x 8-bit register file.
- Drives registered alu_a/alu_b/alu_op to the external combinational ALU, captures alu_result, writes it back, and returns it over a second valid/ready handshake.
- Sits between the control front-end and the ALU datapath.

---
 rtl/alu_cmd_sequencer.sv | 141 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for an external combinational 8-bit ALU: accepts a command,
// reads operands from a 4-entry register file, writes the result back and returns it.
module alu_cmd_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [1:0]       cmd_dst,
  input  logic [1:0]       cmd_sa,
  input  logic [1:0]       cmd_sb,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [1:0]       res_dst,
  output logic             res_err,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             w_accept;
  logic             w_isAluCmd;
  logic             w_isAluLatched;
  logic             w_isLegalLatched;

  logic [2:0]       r_op;
  logic [1:0]       r_dst;
  logic [WIDTH-1:0] r_imm;
  logic [WIDTH-1:0] r_rf [4];
  logic [WIDTH-1:0] r_aluA;
  logic [WIDTH-1:0] r_aluB;
  logic [2:0]       r_aluOp;
  logic             r_resValid;
  logic [WIDTH-1:0] r_resData;
  logic [1:0]       r_resDst;
  logic             r_resErr;
  logic [CNT_W-1:0] r_opCount;

  assign w_accept         = cmd_valid && cmd_ready;
  assign w_isAluCmd       = (cmd_op <= OP_NOT);
  assign w_isAluLatched   = (r_op <= OP_NOT);
  assign w_isLegalLatched = (r_op <= OP_LDI);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_nextState = EXEC;
      EXEC:                   w_nextState = OUT;
      OUT:     if (res_ready) w_nextState = IDLE;
      default:                w_nextState = IDLE;
    endcase
  end

  // Ready is a pure state decode so cmd_valid never reaches cmd_ready combinationally.
  always_comb begin
    cmd_ready = (r_state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_dst      <= '0;
      r_imm      <= '0;
      r_aluA     <= '0;
      r_aluB     <= '0;
      r_aluOp    <= '0;
      r_resValid <= 1'b0;
      r_resData  <= '0;
      r_resDst   <= '0;
      r_resErr   <= 1'b0;
      r_opCount  <= '0;
      for (int i = 0; i < 4; i++) r_rf[i] <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= cmd_op;
        r_dst <= cmd_dst;
        r_imm <= cmd_imm;
        if (w_isAluCmd) begin
          r_aluA  <= r_rf[cmd_sa];
          r_aluB  <= r_rf[cmd_sb];
          r_aluOp <= cmd_op;
        end
      end

      // Writeback happens only here, so the next accepted command always sees it.
      if (r_state == EXEC) begin
        r_resValid <= 1'b1;
        r_resDst   <= r_dst;
        if (w_isAluLatched) begin
          r_rf[r_dst] <= alu_result;
          r_resData   <= alu_result;
          r_resErr    <= 1'b0;
        end else if (r_op == OP_LDI) begin
          r_rf[r_dst] <= r_imm;
          r_resData   <= r_imm;
          r_resErr    <= 1'b0;
        end else begin
          r_resData <= '0;
          r_resErr  <= 1'b1;
        end
        if (w_isLegalLatched && (r_opCount != {CNT_W{1'b1}}))
          r_opCount <= r_opCount + CNT_W'(1);
      end

      if ((r_state == OUT) && res_ready) r_resValid <= 1'b0;
    end
  end

  assign alu_a     = r_aluA;
  assign alu_b     = r_aluB;
  assign alu_op    = r_aluOp;
  assign res_valid = r_resValid;
  assign res_data  = r_resData;
  assign res_dst   = r_resDst;
  assign res_err   = r_resErr;
  assign op_count  = r_opCount;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: a vector table of commands with expected
// results, plus hand sequences for backpressure, saturation and mid-command reset.
module tb_alu_cmd_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmdValid;
  logic        cmdReady;
  logic [2:0]  cmdOp;
  logic [1:0]  cmdDst;
  logic [1:0]  cmdSa;
  logic [1:0]  cmdSb;
  logic [7:0]  cmdImm;
  logic [7:0]  aluA;
  logic [7:0]  aluB;
  logic [2:0]  aluOp;
  logic [7:0]  aluResult;
  logic        resValid;
  logic        resReady;
  logic [7:0]  resData;
  logic [1:0]  resDst;
  logic        resErr;
  logic [15:0] opCount;

  int checkCount;
  int errorCount;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  dst;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [7:0]  imm;
    logic [7:0]  expA;
    logic [7:0]  expB;
    logic [2:0]  expOp;
    logic [7:0]  expData;
    logic        expErr;
    logic [15:0] expCount;
  } vec_t;

  vec_t vecs [15];

  alu_cmd_sequencer #(.WIDTH(8), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmdValid),
    .cmd_ready  (cmdReady),
    .cmd_op     (cmdOp),
    .cmd_dst    (cmdDst),
    .cmd_sa     (cmdSa),
    .cmd_sb     (cmdSb),
    .cmd_imm    (cmdImm),
    .alu_a      (aluA),
    .alu_b      (aluB),
    .alu_op     (aluOp),
    .alu_result (aluResult),
    .res_valid  (resValid),
    .res_ready  (resReady),
    .res_data   (resData),
    .res_dst    (resDst),
    .res_err    (resErr),
    .op_count   (opCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal external ALU.
  always_comb begin
    case (aluOp)
      3'b000:  aluResult = aluA + aluB;
      3'b001:  aluResult = aluA - aluB;
      3'b010:  aluResult = aluA & aluB;
      3'b011:  aluResult = aluA | aluB;
      3'b100:  aluResult = ~aluA;
      default: aluResult = 8'h00;
    endcase
  end

  function automatic vec_t mkVec(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                                 input logic [1:0] sb, input logic [7:0] imm, input logic [7:0] expA,
                                 input logic [7:0] expB, input logic [2:0] expOp, input logic [7:0] expData,
                                 input logic expErr, input logic [15:0] expCount);
    vec_t v;
    v.op = op; v.dst = dst; v.sa = sa; v.sb = sb; v.imm = imm;
    v.expA = expA; v.expB = expB; v.expOp = expOp;
    v.expData = expData; v.expErr = expErr; v.expCount = expCount;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Issue one command, verify 1-cycle latency and the returned result, then drain it.
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    cmdValid = 1'b1; cmdOp = v.op; cmdDst = v.dst; cmdSa = v.sa; cmdSb = v.sb; cmdImm = v.imm;
    checkOutput($sformatf("v%0d_cmd_ready_idle", idx), 32'(cmdReady), 32'd1);
    @(posedge clk); #1;
    checkOutput($sformatf("v%0d_res_valid_exec", idx), 32'(resValid), 32'd0);
    checkOutput($sformatf("v%0d_cmd_ready_exec", idx), 32'(cmdReady), 32'd0);
    @(negedge clk);
    cmdValid = 1'b0;
    @(posedge clk); #1;
    checkOutput($sformatf("v%0d_res_valid", idx), 32'(resValid), 32'd1);
    checkOutput($sformatf("v%0d_res_data", idx), 32'(resData), 32'(v.expData));
    checkOutput($sformatf("v%0d_res_dst", idx), 32'(resDst), 32'(v.dst));
    checkOutput($sformatf("v%0d_res_err", idx), 32'(resErr), 32'(v.expErr));
    checkOutput($sformatf("v%0d_op_count", idx), 32'(opCount), 32'(v.expCount));
    checkOutput($sformatf("v%0d_alu_a", idx), 32'(aluA), 32'(v.expA));
    checkOutput($sformatf("v%0d_alu_b", idx), 32'(aluB), 32'(v.expB));
    checkOutput($sformatf("v%0d_alu_op", idx), 32'(aluOp), 32'(v.expOp));
    @(negedge clk);
    resReady = 1'b1;
    @(posedge clk); #1;
    checkOutput($sformatf("v%0d_res_valid_drop", idx), 32'(resValid), 32'd0);
    checkOutput($sformatf("v%0d_cmd_ready_back", idx), 32'(cmdReady), 32'd1);
    @(negedge clk);
    resReady = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n = 1'b0; cmdValid = 1'b0; cmdOp = '0; cmdDst = '0; cmdSa = '0; cmdSb = '0;
    cmdImm = '0; resReady = 1'b0;

    //               op     dst   sa    sb    imm    A      B      Op     data   err   count
    vecs[0]  = mkVec(3'd5, 2'd0, 2'd0, 2'd0, 8'h05, 8'h00, 8'h00, 3'd0, 8'h05, 1'b0, 16'd1);
    vecs[1]  = mkVec(3'd5, 2'd1, 2'd0, 2'd0, 8'h03, 8'h00, 8'h00, 3'd0, 8'h03, 1'b0, 16'd2);
    vecs[2]  = mkVec(3'd0, 2'd2, 2'd0, 2'd1, 8'h00, 8'h05, 8'h03, 3'd0, 8'h08, 1'b0, 16'd3);
    vecs[3]  = mkVec(3'd1, 2'd3, 2'd1, 2'd0, 8'h00, 8'h03, 8'h05, 3'd1, 8'hFE, 1'b0, 16'd4);
    vecs[4]  = mkVec(3'd5, 2'd0, 2'd0, 2'd0, 8'hFF, 8'h03, 8'h05, 3'd1, 8'hFF, 1'b0, 16'd5);
    vecs[5]  = mkVec(3'd5, 2'd1, 2'd0, 2'd0, 8'h01, 8'h03, 8'h05, 3'd1, 8'h01, 1'b0, 16'd6);
    vecs[6]  = mkVec(3'd0, 2'd0, 2'd0, 2'd1, 8'h00, 8'hFF, 8'h01, 3'd0, 8'h00, 1'b0, 16'd7);
    vecs[7]  = mkVec(3'd3, 2'd2, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 3'd3, 8'h00, 1'b0, 16'd8);
    vecs[8]  = mkVec(3'd4, 2'd1, 2'd1, 2'd3, 8'h00, 8'h01, 8'hFE, 3'd4, 8'hFE, 1'b0, 16'd9);
    vecs[9]  = mkVec(3'd6, 2'd3, 2'd0, 2'd0, 8'h33, 8'h01, 8'hFE, 3'd4, 8'h00, 1'b1, 16'd9);
    vecs[10] = mkVec(3'd3, 2'd3, 2'd3, 2'd3, 8'h00, 8'hFE, 8'hFE, 3'd3, 8'hFE, 1'b0, 16'd10);
    vecs[11] = mkVec(3'd5, 2'd2, 2'd0, 2'd0, 8'h5A, 8'hFE, 8'hFE, 3'd3, 8'h5A, 1'b0, 16'd11);
    vecs[12] = mkVec(3'd2, 2'd2, 2'd2, 2'd3, 8'h00, 8'h5A, 8'hFE, 3'd2, 8'h5A, 1'b0, 16'd12);
    vecs[13] = mkVec(3'd7, 2'd0, 2'd1, 2'd2, 8'h44, 8'h5A, 8'hFE, 3'd2, 8'h00, 1'b1, 16'd12);
    vecs[14] = mkVec(3'd1, 2'd0, 2'd0, 2'd2, 8'h00, 8'h00, 8'h5A, 3'd1, 8'hA6, 1'b0, 16'd13);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_res_valid", 32'(resValid), 32'd0);
    checkOutput("rst_cmd_ready", 32'(cmdReady), 32'd1);
    checkOutput("rst_alu_a", 32'(aluA), 32'd0);
    checkOutput("rst_alu_b", 32'(aluB), 32'd0);
    checkOutput("rst_alu_op", 32'(aluOp), 32'd0);
    checkOutput("rst_res_data", 32'(resData), 32'd0);
    checkOutput("rst_res_err", 32'(resErr), 32'd0);
    checkOutput("rst_op_count", 32'(opCount), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) applyStimulus(vecs[i], i);

    // Backpressure: result must hold while stray commands are ignored.
    @(negedge clk);
    cmdValid = 1'b1; cmdOp = 3'd5; cmdDst = 2'd1; cmdImm = 8'h11;
    @(posedge clk); #1;
    @(negedge clk);
    cmdValid = 1'b0;
    @(posedge clk); #1;
    checkOutput("hold_res_valid_rise", 32'(resValid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      cmdValid = ~cmdValid; cmdOp = 3'd0; cmdDst = 2'd0; cmdSa = 2'd1; cmdSb = 2'd1;
      @(posedge clk); #1;
      checkOutput($sformatf("hold%0d_res_valid", c), 32'(resValid), 32'd1);
      checkOutput($sformatf("hold%0d_res_data", c), 32'(resData), 32'h11);
      checkOutput($sformatf("hold%0d_res_dst", c), 32'(resDst), 32'd1);
      checkOutput($sformatf("hold%0d_cmd_ready", c), 32'(cmdReady), 32'd0);
      checkOutput($sformatf("hold%0d_op_count", c), 32'(opCount), 32'd14);
    end
    @(negedge clk);
    cmdValid = 1'b0; resReady = 1'b1;
    @(posedge clk); #1;
    checkOutput("hold_release_res_valid", 32'(resValid), 32'd0);
    checkOutput("hold_release_cmd_ready", 32'(cmdReady), 32'd1);
    @(negedge clk);
    resReady = 1'b0;
    @(posedge clk); #1;
    checkOutput("hold_no_accept_res_valid", 32'(resValid), 32'd0);
    checkOutput("hold_no_accept_alu_a", 32'(aluA), 32'h00);
    checkOutput("hold_no_accept_alu_b", 32'(aluB), 32'h5A);
    checkOutput("hold_no_accept_alu_op", 32'(aluOp), 32'd1);

    // Counter saturation from a preloaded all-ones value.
    @(negedge clk);
    force dut.r_opCount = 16'hFFFF;
    @(posedge clk); #1;
    release dut.r_opCount;
    checkOutput("sat_preload", 32'(opCount), 32'hFFFF);
    applyStimulus(mkVec(3'd5, 2'd2, 2'd0, 2'd0, 8'h22, 8'h00, 8'h5A, 3'd1, 8'h22, 1'b0, 16'hFFFF), 100);
    applyStimulus(mkVec(3'd0, 2'd3, 2'd1, 2'd2, 8'h00, 8'h11, 8'h22, 3'd0, 8'h33, 1'b0, 16'hFFFF), 101);

    // Reset during EXEC abandons the command and clears everything.
    @(negedge clk);
    cmdValid = 1'b1; cmdOp = 3'd5; cmdDst = 2'd1; cmdImm = 8'h77;
    @(posedge clk); #1;
    checkOutput("rstexec_in_exec", 32'(cmdReady), 32'd0);
    @(negedge clk);
    cmdValid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("rstexec_res_valid", 32'(resValid), 32'd0);
    checkOutput("rstexec_cmd_ready", 32'(cmdReady), 32'd1);
    checkOutput("rstexec_op_count", 32'(opCount), 32'd0);
    checkOutput("rstexec_res_data", 32'(resData), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(mkVec(3'd3, 2'd0, 2'd0, 2'd1, 8'h00, 8'h00, 8'h00, 3'd3, 8'h00, 1'b0, 16'd1), 200);
    applyStimulus(mkVec(3'd3, 2'd2, 2'd2, 2'd3, 8'h00, 8'h00, 8'h00, 3'd3, 8'h00, 1'b0, 16'd2), 201);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
